basic_block_windowed: RTL and testbench

BASIC_BLOCK_WINDOWED -- requirements
Module: basic_block_windowed

---
 rtl/basic_block_windowed.sv | 199 +++++++++++++++++++
 tb/tb_basic_block_windowed.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_block_windowed.sv
// Single-thread instruction executor for a windowed regex engine: fetches the
// instruction at a thread's PC and emits zero, one or two successor threads.

package basic_block_windowed_pkg;
  localparam int unsigned OPCODE_WIDTH = 3;

  localparam logic [OPCODE_WIDTH-1:0] OP_MATCH_CHAR           = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT_MATCH_CHAR       = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_MATCH_ANY            = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP                  = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_SPLIT                = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_ACCEPT               = 3'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_END_WITHOUT_ACCEPTING = 3'd6;
endpackage

module basic_block_windowed
  import basic_block_windowed_pkg::*;
#(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned CHARACTER_WIDTH   = 8,
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned CC_ID_BITS        = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [CHARACTER_WIDTH*(1<<CC_ID_BITS)-1:0]     current_characters,
  input  logic                                           input_pc_valid,
  output logic                                           input_pc_ready,
  input  logic [PC_WIDTH-1:0]                            input_pc,
  input  logic [CC_ID_BITS-1:0]                          input_cc_id,
  output logic                                           memory_valid,
  input  logic                                           memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                   memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                        memory_data,
  output logic                                           output_pc_valid,
  input  logic                                           output_pc_ready,
  output logic [PC_WIDTH-1:0]                            output_pc,
  output logic [CC_ID_BITS-1:0]                          output_cc_id,
  output logic                                           output_pc_is_directed_to_current,
  output logic                                           accepts
);

  localparam int unsigned PAYLOAD_WIDTH = MEMORY_WIDTH - OPCODE_WIDTH;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, EXEC, OUT_A, OUT_B
  } state_t;

  state_t                    state;
  logic [PC_WIDTH-1:0]       pc_q;
  logic [CC_ID_BITS-1:0]     cc_q;
  logic [MEMORY_WIDTH-1:0]   instr_q;
  logic [PC_WIDTH-1:0]       alt_pc_q;
  logic                      split_q;

  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [PC_WIDTH-1:0]       payload_pc;
  logic [PC_WIDTH-1:0]       pc_inc;
  logic [PC_WIDTH-1:0]       emit_pc;
  logic [CHARACTER_WIDTH-1:0] payload_char;
  logic [CHARACTER_WIDTH-1:0] window_char;
  logic [CC_ID_BITS-1:0]     cc_inc;
  logic [CC_ID_BITS-1:0]     emit_cc;
  logic                      emit;
  logic                      advance;
  logic                      is_split;
  logic                      unused_instr;

  // Instruction field extraction and successor arithmetic (wraps naturally)
  assign opcode       = instr_q[MEMORY_WIDTH-1 -: OPCODE_WIDTH];
  assign payload_pc   = PC_WIDTH'(instr_q[PAYLOAD_WIDTH-1:0]);
  assign payload_char = instr_q[CHARACTER_WIDTH-1:0];
  assign window_char  = current_characters[cc_q*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign pc_inc       = pc_q + PC_WIDTH'(1);
  assign cc_inc       = cc_q + CC_ID_BITS'(1);
  assign emit_cc      = advance ? cc_inc : cc_q;
  // Payload bits above the PC/character fields carry no meaning here.
  assign unused_instr = ^instr_q;

  // Decode of the latched instruction, consumed only in EXEC
  always_comb begin
    emit     = 1'b0;
    advance  = 1'b0;
    is_split = 1'b0;
    emit_pc  = pc_inc;
    case (opcode)
      OP_MATCH_CHAR: begin
        emit    = (window_char == payload_char);
        advance = 1'b1;
      end
      OP_NOT_MATCH_CHAR: begin
        emit    = (window_char != payload_char);
        advance = 1'b1;
      end
      OP_MATCH_ANY: begin
        emit    = 1'b1;
        advance = 1'b1;
      end
      OP_JMP: begin
        emit    = 1'b1;
        emit_pc = payload_pc;
      end
      OP_SPLIT: begin
        emit     = 1'b1;
        is_split = 1'b1;
      end
      default: ;
    endcase
  end

  // Thread FSM with all handshake and result outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                            <= IDLE;
      input_pc_ready                   <= 1'b1;
      memory_valid                     <= 1'b0;
      memory_addr                      <= '0;
      output_pc_valid                  <= 1'b0;
      output_pc                        <= '0;
      output_cc_id                     <= '0;
      output_pc_is_directed_to_current <= 1'b0;
      accepts                          <= 1'b0;
      pc_q                             <= '0;
      cc_q                             <= '0;
      instr_q                          <= '0;
      alt_pc_q                         <= '0;
      split_q                          <= 1'b0;
    end else begin
      accepts <= 1'b0;
      case (state)
        IDLE: begin
          if (input_pc_valid) begin
            pc_q           <= input_pc;
            cc_q           <= input_cc_id;
            input_pc_ready <= 1'b0;
            memory_valid   <= 1'b1;
            memory_addr    <= MEMORY_ADDR_WIDTH'(input_pc);
            state          <= FETCH;
          end
        end
        FETCH: begin
          if (memory_ready) begin
            memory_valid <= 1'b0;
            state        <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // Decoding ACCEPT here lets the pulse line up exactly with EXEC.
          instr_q <= memory_data;
          accepts <= (memory_data[MEMORY_WIDTH-1 -: OPCODE_WIDTH] == OP_ACCEPT);
          state   <= EXEC;
        end
        EXEC: begin
          if (emit) begin
            output_pc_valid                  <= 1'b1;
            output_pc                        <= emit_pc;
            output_cc_id                     <= emit_cc;
            output_pc_is_directed_to_current <= !advance;
            alt_pc_q                         <= payload_pc;
            split_q                          <= is_split;
            state                            <= OUT_A;
          end else begin
            input_pc_ready <= 1'b1;
            state          <= IDLE;
          end
        end
        OUT_A: begin
          if (output_pc_ready) begin
            if (split_q) begin
              output_pc                        <= alt_pc_q;
              output_cc_id                     <= cc_q;
              output_pc_is_directed_to_current <= 1'b1;
              state                            <= OUT_B;
            end else begin
              output_pc_valid <= 1'b0;
              input_pc_ready  <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        OUT_B: begin
          if (output_pc_ready) begin
            output_pc_valid <= 1'b0;
            input_pc_ready  <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          output_pc_valid <= 1'b0;
          memory_valid    <= 1'b0;
          input_pc_ready  <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_basic_block_windowed.sv
// Randomized scoreboard bench for basic_block_windowed with a behavioural thread model.

module tb_basic_block_windowed;
  import basic_block_windowed_pkg::*;

  localparam int unsigned PCW = 8;
  localparam int unsigned CW  = 8;
  localparam int unsigned MW  = 16;
  localparam int unsigned MAW = 11;
  localparam int unsigned CCB = 2;
  localparam int unsigned WIN = 4;

  logic                clk;
  logic                reset;
  logic [CW*WIN-1:0]   current_characters;
  logic                input_pc_valid;
  logic                input_pc_ready;
  logic [PCW-1:0]      input_pc;
  logic [CCB-1:0]      input_cc_id;
  logic                memory_valid;
  logic                memory_ready;
  logic [MAW-1:0]      memory_addr;
  logic [MW-1:0]       memory_data;
  logic                output_pc_valid;
  logic                output_pc_ready;
  logic [PCW-1:0]      output_pc;
  logic [CCB-1:0]      output_cc_id;
  logic                output_pc_is_directed_to_current;
  logic                accepts;

  typedef struct {
    int pc;
    int cc;
    int dir;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          exp_acc = 0;
  int          exp_addr = 0;
  logic        hold_ready = 1'b0;
  logic [MW-1:0] prog [0:(1<<MAW)-1];

  basic_block_windowed #(
    .PC_WIDTH(PCW), .CHARACTER_WIDTH(CW), .MEMORY_WIDTH(MW),
    .MEMORY_ADDR_WIDTH(MAW), .CC_ID_BITS(CCB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .current_characters(current_characters),
    .input_pc_valid(input_pc_valid),
    .input_pc_ready(input_pc_ready),
    .input_pc(input_pc),
    .input_cc_id(input_cc_id),
    .memory_valid(memory_valid),
    .memory_ready(memory_ready),
    .memory_addr(memory_addr),
    .memory_data(memory_data),
    .output_pc_valid(output_pc_valid),
    .output_pc_ready(output_pc_ready),
    .output_pc(output_pc),
    .output_cc_id(output_cc_id),
    .output_pc_is_directed_to_current(output_pc_is_directed_to_current),
    .accepts(accepts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int pc, input int cc, input int in_cc);
    exp_t e;
    e.pc  = pc;
    e.cc  = cc;
    e.dir = (cc == in_cc) ? 1 : 0;
    exp_q.push_back(e);
  endfunction

  // Reference: what a thread at (pc, cc) produces for instruction word w
  function automatic void model(input int pc, input int cc, input logic [CW*WIN-1:0] chars,
                                input logic [MW-1:0] w);
    logic [2:0] op;
    int pay, ch, npc, ncc, p;
    op  = w[MW-1:MW-3];
    pay = int'(w[MW-4:0]);
    ch  = int'((chars >> (cc * CW)) & 32'hFF);
    npc = (pc + 1) % (1 << PCW);
    ncc = (cc + 1) % WIN;
    p   = pay % (1 << PCW);
    case (op)
      OP_MATCH_CHAR:     if (ch == pay % 256) push(npc, ncc, cc);
      OP_NOT_MATCH_CHAR: if (ch != pay % 256) push(npc, ncc, cc);
      OP_MATCH_ANY:      push(npc, ncc, cc);
      OP_JMP:            push(p, cc, cc);
      OP_SPLIT: begin
        push(npc, cc, cc);
        push(p, cc, cc);
      end
      OP_ACCEPT:         exp_acc++;
      default: ;
    endcase
  endfunction

  // Backpressure generator for the two DUT-facing ready inputs
  initial begin
    memory_ready    = 1'b0;
    output_pc_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      memory_ready    = ($urandom_range(0, 3) != 0);
      output_pc_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Instruction memory: data appears the cycle after a fetch handshake, junk otherwise
  initial begin
    logic hs;
    logic [MAW-1:0] a;
    memory_data = '0;
    forever begin
      @(posedge clk);
      hs = memory_valid && memory_ready && reset;
      a  = memory_addr;
      #1;
      if (hs) begin
        check("memory_addr", int'(a), exp_addr);
        memory_data = prog[a];
      end else begin
        memory_data = MW'($urandom);
      end
    end
  end

  // Monitor: scoreboard pop on each output handshake, accept pulse counting
  initial begin
    logic prev_acc;
    logic waiting;
    int h_pc, h_cc, h_dir;
    exp_t e;
    prev_acc = 1'b0;
    waiting  = 1'b0;
    h_pc = 0; h_cc = 0; h_dir = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_acc = 1'b0;
        waiting  = 1'b0;
      end else begin
        if (accepts) begin
          n_acc++;
          check("accepts_single_cycle", int'(prev_acc), 0);
        end
        prev_acc = accepts;
        if (output_pc_valid && waiting) begin
          check("held_pc", int'(output_pc), h_pc);
          check("held_cc_id", int'(output_cc_id), h_cc);
          check("held_directed", int'(output_pc_is_directed_to_current), h_dir);
        end
        if (output_pc_valid && output_pc_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output_valid", int'(output_pc_valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("output_pc", int'(output_pc), e.pc);
            check("output_cc_id", int'(output_cc_id), e.cc);
            check("output_directed", int'(output_pc_is_directed_to_current), e.dir);
          end
        end
        waiting = output_pc_valid && !output_pc_ready;
        h_pc  = int'(output_pc);
        h_cc  = int'(output_cc_id);
        h_dir = int'(output_pc_is_directed_to_current);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (input_pc_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (input_pc_ready !== 1'b1) check(name, int'(input_pc_ready), 1);
  endtask

  task automatic start_thread(input int pc, input int cc, input logic [MW-1:0] w,
                              input logic [CW*WIN-1:0] chars);
    wait_idle("timeout_waiting_idle");
    prog[pc]           = w;
    current_characters = chars;
    exp_addr           = pc;
    model(pc, cc, chars, w);
    input_pc       = PCW'(pc);
    input_cc_id    = CCB'(cc);
    input_pc_valid = 1'b1;
    @(negedge clk);
    input_pc_valid = 1'b0;
    input_pc       = PCW'($urandom);
    check("input_pc_ready_busy", int'(input_pc_ready), 0);
  endtask

  task automatic run_thread(input int pc, input int cc, input logic [MW-1:0] w,
                            input logic [CW*WIN-1:0] chars);
    start_thread(pc, cc, w, chars);
    wait_idle("timeout_thread_done");
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!output_pc_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(output_pc_valid), 1);
  endtask

  initial begin
    int pc, cc;
    logic [2:0] op;
    logic [MW-4:0] pay;
    logic [CW*WIN-1:0] chars;

    reset              = 1'b1;
    input_pc_valid     = 1'b0;
    input_pc           = '0;
    input_cc_id        = '0;
    current_characters = '0;
    for (int i = 0; i < (1 << MAW); i++) prog[i] = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_input_pc_ready", int'(input_pc_ready), 1);
    check("rst_memory_valid", int'(memory_valid), 0);
    check("rst_output_pc_valid", int'(output_pc_valid), 0);
    check("rst_accepts", int'(accepts), 0);
    check("rst_output_pc", int'(output_pc), 0);
    check("rst_output_cc_id", int'(output_cc_id), 0);
    check("rst_memory_addr", int'(memory_addr), 0);
    check("rst_directed", int'(output_pc_is_directed_to_current), 0);
    reset = 1'b1;
    @(negedge clk);

    // END_WITHOUT_ACCEPTING: no output, no accept, back to idle
    run_thread(8'hCC, 0, {OP_END_WITHOUT_ACCEPTING, 13'h0}, 32'($urandom));
    repeat (10) @(negedge clk);
    check("end_ready_idle", int'(input_pc_ready), 1);
    check("end_accept_count", n_acc, exp_acc);

    // MATCH_CHAR hit and miss on slot 2
    chars = {8'h11, 8'h61, 8'h22, 8'h33};
    run_thread(8'h10, 2, {OP_MATCH_CHAR, 13'h061}, chars);
    run_thread(8'h10, 2, {OP_MATCH_CHAR, 13'h062}, chars);

    // SPLIT with consumer stalled for 5 cycles on the first output
    hold_ready = 1'b1;
    @(negedge clk);
    start_thread(8'h20, 1, {OP_SPLIT, 13'h040}, 32'($urandom));
    wait_out_valid("split_a_valid");
    check("split_a_pc", int'(output_pc), 'h21);
    check("split_a_cc", int'(output_cc_id), 1);
    repeat (5) @(negedge clk);
    check("split_a_still_valid", int'(output_pc_valid), 1);
    hold_ready = 1'b0;
    wait_idle("timeout_split_done");

    // PC and cc_id wrap
    run_thread(8'hFF, 3, {OP_MATCH_ANY, 13'h0}, 32'($urandom));

    // ACCEPT pulse
    run_thread(8'h05, 0, {OP_ACCEPT, 13'h0}, 32'($urandom));
    check("accept_count_after_accept", n_acc, exp_acc);

    // Reset while the first SPLIT output is pending
    hold_ready = 1'b1;
    @(negedge clk);
    start_thread(8'h30, 2, {OP_SPLIT, 13'h077}, 32'($urandom));
    wait_out_valid("reset_split_a_valid");
    reset = 1'b0;
    #1;
    check("midsplit_rst_valid", int'(output_pc_valid), 0);
    check("midsplit_rst_pc", int'(output_pc), 0);
    check("midsplit_rst_cc", int'(output_cc_id), 0);
    check("midsplit_rst_directed", int'(output_pc_is_directed_to_current), 0);
    check("midsplit_rst_ready", int'(input_pc_ready), 1);
    check("midsplit_rst_mem_valid", int'(memory_valid), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hold_ready = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(input_pc_ready), 1);
    repeat (10) @(negedge clk);
    check("post_reset_no_valid", int'(output_pc_valid), 0);

    // Randomized threads
    for (int t = 0; t < 250; t++) begin
      pc    = $urandom_range(0, 255);
      cc    = $urandom_range(0, 3);
      chars = 32'($urandom);
      op    = 3'($urandom_range(0, 7));
      pay   = (MW-3)'($urandom);
      if ((op == OP_MATCH_CHAR || op == OP_NOT_MATCH_CHAR) && ($urandom_range(0, 1) == 1))
        pay[CW-1:0] = chars[cc*CW +: CW];
      run_thread(pc, cc, {op, pay}, chars);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("accept_count_final", n_acc, exp_acc);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
